// File: rtl/ncl_tx_2rail.sv
// ncl_tx_2rail: clocked valid/ready to two-rail NCL wavefront transmitter.
// Define NCL_TX_STATS_EN to add the wave_count port and its counter.
module ncl_tx_2rail #(
    parameter int WIDTH = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] Z,
    input  logic               ZCOMP
`ifdef NCL_TX_STATS_EN
    ,
    output logic [15:0]        wave_count
`endif
);
    typedef enum logic [1:0] {S_WAIT, S_IDLE, S_DATA, S_NULL} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sync;
    logic [WIDTH-1:0] hold;
    logic [2*WIDTH-1:0] enc;
    logic zs, hold_full, load, unload;
    assign zs = sync[SYNC_STAGES-1];
    assign in_ready = init_n && !hold_full;
    assign load = in_valid && in_ready;
    assign unload = state == S_IDLE && hold_full && !zs;
    for (genvar i = 0; i < WIDTH; i++) begin : g_enc
        assign enc[2*i+1:2*i] = {hold[i], !hold[i]};
    end
    // Synchronizer resets to request-for-NULL so a torn downstream wavefront is flushed first
    always_ff @(posedge clk or negedge init_n)
        if (!init_n) sync <= '1;
        else sync <= {sync[SYNC_STAGES-2:0], ZCOMP};
    always_ff @(posedge clk or negedge init_n)
        if (!init_n) begin
            hold_full <= 1'b0;
            hold <= '0;
        end else begin
            hold_full <= load || (hold_full && !unload);
            if (load) hold <= in_data;
        end
    always_ff @(posedge clk or negedge init_n)
        if (!init_n) begin
            state <= S_WAIT;
            Z <= '0;
        end else
            case (state)
                S_WAIT: if (!zs) state <= S_IDLE;
                S_IDLE: if (unload) begin
                    Z <= enc;
                    state <= S_DATA;
                end
                S_DATA: if (zs) begin
                    Z <= '0;
                    state <= S_NULL;
                end
                default: if (!zs) state <= S_IDLE;
            endcase
`ifdef NCL_TX_STATS_EN
    always_ff @(posedge clk or negedge init_n)
        if (!init_n) wave_count <= '0;
        else if (state == S_NULL && !zs) wave_count <= wave_count + 16'd1;
`endif
endmodule

// File: tb/tb_ncl_tx_2rail.sv
// tb_ncl_tx_2rail: directed checks of the NCL two-rail transmitter handshake and encoding.
module tb_ncl_tx_2rail;
    logic clk = 1'b0;
    logic init_n, in_valid, in_ready, ZCOMP;
    logic [3:0] in_data;
    logic [7:0] Z;
`ifdef NCL_TX_STATS_EN
    logic [15:0] wave_count;
`endif
    int checks = 0;
    int errors = 0;

    ncl_tx_2rail #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .init_n(init_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .Z(Z),
        .ZCOMP(ZCOMP)
`ifdef NCL_TX_STATS_EN
        ,
        .wave_count(wave_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait for Z to become non-NULL (want_data) or NULL
    task automatic wait_z(input string tag, input logic want_data);
        int n = 0;
        while (((Z != 8'h00) != want_data) && n < 30) begin
            step();
            n++;
        end
        chk(tag, 16'(n < 30), 16'd1);
    endtask

    initial begin
        logic [3:0] dv;
        logic [7:0] held;
        logic seen_null;
        int bad;
        init_n = 1'b0;
        ZCOMP = 1'b1;
        in_valid = 1'b0;
        in_data = 4'h0;
        #3;
        chk("reset_z", 16'(Z), 16'h00);
        chk("reset_ready", 16'(in_ready), 16'd0);
`ifdef NCL_TX_STATS_EN
        chk("reset_count", wave_count, 16'h0000);
`endif
        step();
        step();
        init_n = 1'b1;
        #1;
        chk("release_ready", 16'(in_ready), 16'd1);
        ZCOMP = 1'b0;
        step();
        step();
        step();
        chk("startup_z", 16'(Z), 16'h00);

        // single word 0xA
        in_valid = 1'b1;
        in_data = 4'hA;
        step();
        chk("single_hold_ready", 16'(in_ready), 16'd0);
        in_valid = 1'b0;
        step();
        chk("single_data", 16'(Z), 16'h99);
        chk("single_ready_back", 16'(in_ready), 16'd1);
        ZCOMP = 1'b1;
        step();
        step();
        chk("single_data_held", 16'(Z), 16'h99);
        step();
        chk("single_null", 16'(Z), 16'h00);
        ZCOMP = 1'b0;
        step();
        step();
        step();
`ifdef NCL_TX_STATS_EN
        chk("single_count", wave_count, 16'h0001);
`endif

        // back-pressure: 0x3 then 0x5 with ZCOMP stuck high
        in_valid = 1'b1;
        in_data = 4'h3;
        step();
        step();
        chk("bp_first_data", 16'(Z), 16'h5A);
        in_data = 4'h5;
        ZCOMP = 1'b1;
        step();
        chk("bp_second_held", 16'(in_ready), 16'd0);
        in_data = 4'h7;
        for (int i = 0; i < 6; i++) step();
        chk("bp_null", 16'(Z), 16'h00);
        chk("bp_third_blocked", 16'(in_ready), 16'd0);
        in_valid = 1'b0;
        ZCOMP = 1'b0;
        wait_z("bp_wait_data", 1'b1);
        chk("bp_second_data", 16'(Z), 16'h66);
        ZCOMP = 1'b1;
        wait_z("bp_wait_null", 1'b0);
        ZCOMP = 1'b0;
        step();
        step();
        step();
`ifdef NCL_TX_STATS_EN
        chk("bp_count", wave_count, 16'h0003);
`endif

        // encoding sweep with a decoding sink
        for (int v = 0; v < 16; v++) begin
            in_valid = 1'b1;
            in_data = 4'(v);
            step();
            in_valid = 1'b0;
            wait_z("sweep_wait_data", 1'b1);
            bad = 0;
            dv = 4'h0;
            for (int d = 0; d < 4; d++) begin
                if (Z[2*d+:2] == 2'b10) dv[d] = 1'b1;
                else if (Z[2*d+:2] != 2'b01) bad++;
            end
            chk("sweep_one_rail", 16'(bad), 16'd0);
            chk("sweep_decode", 16'(dv), 16'(v));
            held = Z;
            seen_null = 1'b0;
            ZCOMP = 1'b1;
            for (int i = 0; i < 6; i++) begin
                step();
                if (Z == 8'h00) seen_null = 1'b1;
                else chk("sweep_stable", 16'({seen_null, Z}), 16'({1'b0, held}));
            end
            chk("sweep_null", 16'(Z), 16'h00);
            ZCOMP = 1'b0;
            step();
            step();
            step();
        end

        // reset mid-DATA
        in_valid = 1'b1;
        in_data = 4'hA;
        step();
        in_valid = 1'b0;
        step();
        chk("mid_data", 16'(Z), 16'h99);
        #2;
        init_n = 1'b0;
        #1;
        chk("mid_reset_z", 16'(Z), 16'h00);
        chk("mid_reset_ready", 16'(in_ready), 16'd0);
`ifdef NCL_TX_STATS_EN
        chk("mid_reset_count", wave_count, 16'h0000);
`endif
        ZCOMP = 1'b1;
        step();
        init_n = 1'b1;
        in_valid = 1'b1;
        in_data = 4'h5;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("mid_no_data_until_rfd", 16'(Z), 16'h00);
        ZCOMP = 1'b0;
        wait_z("mid_wait_data", 1'b1);
        chk("mid_after_rfd", 16'(Z), 16'h66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
